matrix_capture: RTL and testbench
=================================

Name: matrix_capture

Overview:
- Receive-side decoder for the 16x16 LED matrix shift-register interface (RCLK, RSDI, OEB, CSDI, CCLK, LE) driven by the pong core.
- Samples the serial lines in the clk32mhz domain, rebuilds the 16x16 frame in an internal buffer, and exposes it through a registered row-read port plus frame/error status.
- Used on-chip for logic-analyzer readback of the display, and in benches as the display model.

Parameters:
SYNC_STAGES, 2, number of input synchroniser flops per serial line (min 1)
FRAME_CNT_WIDTH, 8, width of the frame counter

Ports:
clk32mhz  input  1  system clock; the only clock
reset_n  input  1  synchronous, active-low reset
RCLK  input  1  row shift clock; rising edge shifts RSDI
RSDI  input  1  row serial data; 1 = row selected
CCLK  input  1  column shift clock; rising edge shifts CSDI
CSDI  input  1  column serial data; 1 = pixel lit
LE  input  1  latch enable; rising edge latches the column shifter
OEB  input  1  output enable bar; falling edge commits the latched row
rd_row  input  4  row index to read
rd_data  output  16  pixels of rd_row; bit c = column c
frame_done  output  1  one-cycle pulse on frame completion
frame_count  output  FRAME_CNT_WIDTH  completed frames, wraps
proto_err  output  1  sticky protocol-error flag
clr_err  input  1  clears proto_err

Behaviour:
- One clock (clk32mhz); reset synchronous, active-low (reset_n); all state updates on rising clk32mhz.
- Each serial input passes through SYNC_STAGES flops, then one edge-detect flop. An input edge is acted on exactly SYNC_STAGES+1 cycles after it.
- Column shifter col_sr[15:0]: on CCLK rise, col_sr <= {col_sr[14:0], CSDI_sync}. The first bit shifted lands in bit 15 after 16 shifts. col_cnt (5 bits) increments and saturates at 31.
- Row shifter row_sr[15:0]: on RCLK rise, row_sr <= {row_sr[14:0], RSDI_sync}.
- LE rise:
  - col_latch <= col_sr, as updated by a CCLK rise in the same cycle.
  - If col_cnt != 16, set proto_err.
  - col_cnt <= 0; a CCLK rise in the same cycle makes col_cnt 1 instead.
- OEB fall (commit):
  - If row_sr is exactly one-hot at bit r: frame[r] <= col_latch and mark_r <= 1.
  - Otherwise (zero or multiple bits set): no write, and set proto_err.
- Frame completion:
  - On a commit to row 15 with all 16 marks set: frame_done pulses high the next cycle, frame_count increments (wraps at 2^FRAME_CNT_WIDTH-1 -> 0), and all marks clear.
  - A commit to row 15 with marks missing clears the marks without a pulse and sets proto_err.
- Simultaneous edges in one cycle are processed in this order: CCLK/RCLK shift, then LE latch, then OEB commit. The commit uses the newly latched col_latch.
- OEB rise, and any edge outside the cases above: no action.
- Read port: rd_data <= frame[rd_row] registered, 1-cycle latency. A commit and a read of the same row in the same cycle returns the old row data.
- proto_err: sticky. clr_err clears it; a new error in the same cycle as clr_err wins (flag stays 1).
- Reset (reset_n=0, any cycle including mid-shift or mid-frame) clears:
  - synchronisers, preloaded to idle values (clocks 0, OEB 1, so no false edge at release)
  - col_sr, row_sr, col_latch, col_cnt, marks
  - frame buffer
  - outputs: rd_data=0, frame_done=0, frame_count=0, proto_err=0
- Storage: 256 flops plus 16 mark bits, no RAM macro.

Test Plan:
1. Reset, then hold all inputs idle 100 cycles -> rd_data=0 for every rd_row, frame_done never pulses, frame_count=0, proto_err=0.
2. Shift RSDI=1 then 3x0 (row_sr=0x0008), shift CSDI 16 bits 0xA5C3 MSB-first, pulse LE, drop OEB -> rd_row=3 reads 0xA5C3 one cycle after the read request; commit lands exactly SYNC_STAGES+1 cycles after the OEB fall.
3. Full frame writing row r = 16'h0001<<r for r=0..15 with a walking row bit -> a single frame_done pulse after row 15, frame_count=1, rd_row=7 reads 0x0080. Repeat 256 frames -> frame_count wraps to 0.
4. LE after 15 CCLK pulses -> proto_err=1. clr_err asserted -> 0 next cycle. clr_err asserted together with a new error -> stays 1.
5. OEB fall with row_sr=0x0011 -> no frame write (row 0 and row 4 unchanged), proto_err=1. A frame skipping row 9 -> no frame_done at the row 15 commit.
6. reset_n low for 1 cycle mid-frame (after row 8 commit) -> all rows read 0, frame_count=0; the next complete frame produces frame_done with count 1.

Source files
------------

// File: rtl/matrix_capture.sv
// Receive-side decoder for the 16x16 LED matrix shift-register interface.
// Rebuilds the displayed frame from the serial lines and exposes it via a registered row-read port.
module matrix_capture #(
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned FRAME_CNT_WIDTH = 8
) (
    input  logic                       clk32mhz,
    input  logic                       reset_n,
    input  logic                       RCLK,
    input  logic                       RSDI,
    input  logic                       CCLK,
    input  logic                       CSDI,
    input  logic                       LE,
    input  logic                       OEB,
    input  logic [3:0]                 rd_row,
    output logic [15:0]                rd_data,
    output logic                       frame_done,
    output logic [FRAME_CNT_WIDTH-1:0] frame_count,
    output logic                       proto_err,
    input  logic                       clr_err
);

    localparam int unsigned NLINES = 6;
    localparam int unsigned L_RCLK = 0;
    localparam int unsigned L_RSDI = 1;
    localparam int unsigned L_CCLK = 2;
    localparam int unsigned L_CSDI = 3;
    localparam int unsigned L_LE   = 4;
    localparam int unsigned L_OEB  = 5;
    localparam int unsigned ROWS   = 16;
    localparam int unsigned COLS   = 16;
    localparam int unsigned CNT_W  = 5;

    // Idle line levels: clocks and LE low, OEB high, so reset release produces no edge
    localparam logic [NLINES-1:0] LINE_IDLE = 6'b100000;
    localparam logic [3:0]        PREV_IDLE = 4'b1000;  // {oeb, le, cclk, rclk}

    logic [NLINES-1:0]          sync_q [SYNC_STAGES];
    logic [NLINES-1:0]          line_s;
    logic [3:0]                 prev_q;

    logic [COLS-1:0]            col_sr_q, col_sr_d;
    logic [COLS-1:0]            row_sr_q, row_sr_d;
    logic [COLS-1:0]            col_latch_q, col_latch_d;
    logic [CNT_W-1:0]           col_cnt_q, col_cnt_d, cnt_shift;
    logic [ROWS-1:0]            marks_q, marks_d;
    logic [COLS-1:0]            frame_q [ROWS];
    logic [COLS-1:0]            frame_d [ROWS];
    logic [COLS-1:0]            rd_data_q, rd_data_d;
    logic                       frame_done_q, frame_done_d;
    logic [FRAME_CNT_WIDTH-1:0] frame_count_q, frame_count_d;
    logic                       proto_err_q, proto_err_d;

    logic rclk_rise, cclk_rise, le_rise, oeb_fall;
    logic row_one_hot;
    logic [3:0] row_idx;
    logic err_set;

    assign line_s    = sync_q[SYNC_STAGES-1];
    assign rclk_rise = line_s[L_RCLK] & ~prev_q[0];
    assign cclk_rise = line_s[L_CCLK] & ~prev_q[1];
    assign le_rise   = line_s[L_LE]   & ~prev_q[2];
    assign oeb_fall  = ~line_s[L_OEB] &  prev_q[3];

    // Shift stage: both shifters advance before any latch or commit in the same cycle
    always_comb begin
        col_sr_d  = col_sr_q;
        cnt_shift = col_cnt_q;
        row_sr_d  = row_sr_q;
        if (cclk_rise) begin
            col_sr_d = {col_sr_q[COLS-2:0], line_s[L_CSDI]};
            if (col_cnt_q != 5'd31) begin
                cnt_shift = col_cnt_q + 5'd1;
            end
        end
        if (rclk_rise) begin
            row_sr_d = {row_sr_q[COLS-2:0], line_s[L_RSDI]};
        end
    end

    // Row select decode of the post-shift row register
    always_comb begin
        row_one_hot = (row_sr_d != '0) && ((row_sr_d & (row_sr_d - 16'd1)) == '0);
        row_idx     = '0;
        for (int unsigned i = 0; i < ROWS; i++) begin
            if (row_sr_d[i]) begin
                row_idx = 4'(i);
            end
        end
    end

    // Latch, commit and frame-completion logic
    always_comb begin
        col_cnt_d     = cnt_shift;
        col_latch_d   = col_latch_q;
        marks_d       = marks_q;
        frame_d       = frame_q;
        frame_count_d = frame_count_q;
        frame_done_d  = 1'b0;
        err_set       = 1'b0;
        rd_data_d     = frame_q[rd_row];

        if (le_rise) begin
            col_latch_d = col_sr_d;
            if (cnt_shift != 5'd16) begin
                err_set = 1'b1;
            end
            col_cnt_d = cclk_rise ? 5'd1 : 5'd0;
        end

        if (oeb_fall) begin
            if (row_one_hot) begin
                frame_d[row_idx] = col_latch_d;
                marks_d[row_idx] = 1'b1;
                if (row_idx == 4'd15) begin
                    if (&marks_d) begin
                        frame_done_d  = 1'b1;
                        frame_count_d = frame_count_q + FRAME_CNT_WIDTH'(1);
                    end else begin
                        err_set = 1'b1;
                    end
                    marks_d = '0;
                end
            end else begin
                err_set = 1'b1;
            end
        end

        // A fresh error outranks a clear in the same cycle
        proto_err_d = err_set | (proto_err_q & ~clr_err);
    end

    always_ff @(posedge clk32mhz) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= LINE_IDLE;
            end
            prev_q        <= PREV_IDLE;
            col_sr_q      <= '0;
            row_sr_q      <= '0;
            col_latch_q   <= '0;
            col_cnt_q     <= '0;
            marks_q       <= '0;
            for (int unsigned i = 0; i < ROWS; i++) begin
                frame_q[i] <= '0;
            end
            rd_data_q     <= '0;
            frame_done_q  <= 1'b0;
            frame_count_q <= '0;
            proto_err_q   <= 1'b0;
        end else begin
            sync_q[0] <= {OEB, LE, CSDI, CCLK, RSDI, RCLK};
            for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            prev_q        <= {line_s[L_OEB], line_s[L_LE], line_s[L_CCLK], line_s[L_RCLK]};
            col_sr_q      <= col_sr_d;
            row_sr_q      <= row_sr_d;
            col_latch_q   <= col_latch_d;
            col_cnt_q     <= col_cnt_d;
            marks_q       <= marks_d;
            frame_q       <= frame_d;
            rd_data_q     <= rd_data_d;
            frame_done_q  <= frame_done_d;
            frame_count_q <= frame_count_d;
            proto_err_q   <= proto_err_d;
        end
    end

    assign rd_data     = rd_data_q;
    assign frame_done  = frame_done_q;
    assign frame_count = frame_count_q;
    assign proto_err   = proto_err_q;

endmodule

// File: tb/tb_matrix_capture.sv
// Bench for matrix_capture: drives the serial protocol and compares against a frame-level model.
module tb_matrix_capture;

    localparam int S = 2;
    localparam int W = 8;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        RCLK = 1'b0, RSDI = 1'b0, CCLK = 1'b0, CSDI = 1'b0, LE = 1'b0, OEB = 1'b1;
    logic [3:0]  rd_row = 4'd0;
    logic [15:0] rd_data;
    logic        frame_done;
    logic [W-1:0] frame_count;
    logic        proto_err;
    logic        clr_err = 1'b0;

    always #5 clk = ~clk;

    matrix_capture #(.SYNC_STAGES(S), .FRAME_CNT_WIDTH(W)) dut (
        .clk32mhz(clk), .reset_n(reset_n),
        .RCLK(RCLK), .RSDI(RSDI), .CCLK(CCLK), .CSDI(CSDI), .LE(LE), .OEB(OEB),
        .rd_row(rd_row), .rd_data(rd_data), .frame_done(frame_done),
        .frame_count(frame_count), .proto_err(proto_err), .clr_err(clr_err)
    );

    // Model state: what the display should hold given the protocol events so far
    logic [15:0] m_col, m_row, m_latch, m_marks;
    logic [15:0] m_frame [16];
    int          m_ccnt, m_count, m_done;
    bit          m_err;

    int errors = 0, checks = 0, n_pulses = 0;
    bit chk_en = 1'b0, en_prev = 1'b0;
    int fix_row = -1, prev_row = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_col = '0; m_row = '0; m_latch = '0; m_marks = '0;
        m_ccnt = 0; m_count = 0; m_err = 1'b0;
        for (int i = 0; i < 16; i++) m_frame[i] = '0;
    endfunction

    function automatic void m_oeb();
        int r;
        if ($countones(m_row) != 1) begin
            m_err = 1'b1;
            return;
        end
        r = 0;
        for (int i = 0; i < 16; i++) if (m_row[i]) r = i;
        m_frame[r] = m_latch;
        m_marks[r] = 1'b1;
        if (r == 15) begin
            if (m_marks == 16'hFFFF) begin
                m_done++;
                m_count = (m_count + 1) % (1 << W);
            end else begin
                m_err = 1'b1;
            end
            m_marks = '0;
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cclk(input logic b);
        CSDI = b; CCLK = 1'b1; tick(); CCLK = 1'b0; tick();
        m_col = {m_col[14:0], b};
        m_ccnt = (m_ccnt < 31) ? m_ccnt + 1 : 31;
    endtask

    task automatic rclk(input logic b);
        RSDI = b; RCLK = 1'b1; tick(); RCLK = 1'b0; tick();
        m_row = {m_row[14:0], b};
    endtask

    task automatic le_pulse();
        LE = 1'b1; tick(); LE = 1'b0; tick();
        m_latch = m_col;
        if (m_ccnt != 16) m_err = 1'b1;
        m_ccnt = 0;
    endtask

    task automatic oeb_pulse();
        OEB = 1'b0; tick(); OEB = 1'b1; tick();
        m_oeb();
    endtask

    task automatic settle();
        repeat (S + 3) tick();
    endtask

    task automatic send_word(input logic [15:0] word, input int nbits);
        for (int i = 0; i < nbits; i++) cclk((i < 16) ? word[15-i] : 1'b0);
    endtask

    task automatic clear_err();
        chk_en = 1'b0;
        clr_err = 1'b1; tick(); clr_err = 1'b0;
        m_err = 1'b0;
        settle();
        chk_en = 1'b1;
    endtask

    task automatic read_row(input int r, input logic [15:0] exp, input string name);
        fix_row = r;
        repeat (3) tick();
        check(name, 32'(rd_data), 32'(exp));
        fix_row = -1;
    endtask

    // Row 0 flushes the row shifter so the walk starts clean from any prior state
    task automatic full_frame(input int skip, input int last, input bit rnd);
        logic [15:0] word;
        int nb;
        for (int r = 0; r <= last; r++) begin
            chk_en = 1'b0;
            word = rnd ? 16'($urandom) : (16'd1 << r);
            nb = 16;
            if (rnd && $urandom_range(0, 5) == 0) nb = $urandom_range(15, 17);
            send_word(word, nb);
            le_pulse();
            if (r == 0) for (int i = 15; i >= 0; i--) rclk(i == 0);
            else rclk(1'b0);
            if (r != skip) oeb_pulse();
            settle();
            chk_en = 1'b1;
        end
    endtask

    // Commits every row with the current latch; expects row_sr = 0x8000 on entry
    task automatic fast_frame();
        chk_en = 1'b0;
        for (int r = 0; r < 16; r++) begin
            rclk(r == 0);
            oeb_pulse();
        end
        settle();
        chk_en = 1'b1;
    endtask

    // Cycle-by-cycle comparison against the model whenever the bus is quiet
    always @(negedge clk) begin
        if (frame_done) n_pulses++;
        if (chk_en) begin
            check("frame_done_idle", 32'(frame_done), 32'd0);
            check("frame_count", 32'(frame_count), 32'(m_count));
            check("proto_err", 32'(proto_err), 32'(m_err));
            check("pulse_count", 32'(n_pulses), 32'(m_done));
            if (en_prev) check("rd_data", 32'(rd_data), 32'(m_frame[prev_row]));
        end
        en_prev  = chk_en;
        prev_row = (fix_row >= 0) ? fix_row : int'($urandom_range(0, 15));
        rd_row   = 4'(prev_row);
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [15:0] w;
        int skip;
        model_reset();
        m_done = 0;
        repeat (3) tick();
        reset_n = 1'b1;
        settle();
        chk_en = 1'b1;

        // Idle after reset
        repeat (100) tick();
        check("idle_count", 32'(frame_count), 32'd0);
        check("idle_err", 32'(proto_err), 32'd0);

        // Single commit to row 3 and its exact latency
        chk_en = 1'b0;
        rclk(1'b1); rclk(1'b0); rclk(1'b0); rclk(1'b0);
        w = 16'hA5C3;
        send_word(w, 16);
        le_pulse();
        fix_row = 3;
        tick(); tick();
        OEB = 1'b0;
        repeat (S + 1) tick();
        check("row3_before_commit", 32'(rd_data), 32'h0);
        tick();
        check("row3_after_commit", 32'(rd_data), 32'hA5C3);
        OEB = 1'b1; tick();
        m_oeb();
        settle();
        fix_row = -1;
        chk_en = 1'b1;

        // Diagonal frame, then wrap of the frame counter
        full_frame(-1, 15, 1'b0);
        check("diag_count", 32'(frame_count), 32'd1);
        check("diag_err", 32'(proto_err), 32'd0);
        read_row(7, 16'h0080, "diag_row7");
        repeat (255) fast_frame();
        check("wrap_count", 32'(frame_count), 32'd0);
        check("wrap_pulses", 32'(n_pulses), 32'd256);

        // Short column load, clear, and clear racing a new error
        chk_en = 1'b0;
        repeat (15) cclk(1'b1);
        le_pulse();
        settle();
        check("short_le_err", 32'(proto_err), 32'd1);
        clr_err = 1'b1; tick(); clr_err = 1'b0;
        check("clr_err", 32'(proto_err), 32'd0);
        m_err = 1'b0;
        repeat (15) cclk(1'b1);
        LE = 1'b1;
        repeat (S) tick();
        check("err_not_early", 32'(proto_err), 32'd0);
        clr_err = 1'b1; tick(); clr_err = 1'b0;
        check("clr_vs_new_err", 32'(proto_err), 32'd1);
        LE = 1'b0; tick();
        m_latch = m_col; m_ccnt = 0; m_err = 1'b1;
        settle();
        check("err_sticky", 32'(proto_err), 32'd1);
        chk_en = 1'b1;
        clear_err();

        // Two-hot row select and a frame missing row 9
        chk_en = 1'b0;
        w = 16'h1234;
        send_word(w, 16);
        le_pulse();
        rclk(1'b1); rclk(1'b0); rclk(1'b0); rclk(1'b0); rclk(1'b1);
        oeb_pulse();
        settle();
        chk_en = 1'b1;
        check("twohot_err", 32'(proto_err), 32'd1);
        read_row(0, 16'h8000, "twohot_row0");
        read_row(4, 16'h8000, "twohot_row4");
        clear_err();
        full_frame(9, 15, 1'b0);
        check("skip9_count", 32'(frame_count), 32'd0);
        check("skip9_pulses", 32'(n_pulses), 32'd256);
        check("skip9_err", 32'(proto_err), 32'd1);

        // Randomised frames with occasional bad column counts and skipped rows
        repeat (4) begin
            clear_err();
            skip = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15)) : -1;
            full_frame(skip, 15, 1'b1);
        end

        // Reset in the middle of a frame
        clear_err();
        full_frame(-1, 8, 1'b0);
        chk_en = 1'b0;
        reset_n = 1'b0; tick(); reset_n = 1'b1;
        model_reset();
        settle();
        chk_en = 1'b1;
        for (int r = 0; r < 16; r++) read_row(r, 16'h0, "post_reset_row");
        check("post_reset_count", 32'(frame_count), 32'd0);
        full_frame(-1, 15, 1'b0);
        check("post_reset_frame", 32'(frame_count), 32'd1);
        read_row(7, 16'h0080, "post_reset_row7");

        chk_en = 1'b0;
        tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
